atm_txn_scheduler: RTL and testbench
====================================

# atm_txn_scheduler

Transaction scheduler that shares one account-balance store among `NUM_TERM` ATM front-end FSMs. Each terminal posts a request: operation, source and destination account index, and amount. The block picks one request by round-robin and runs the read/check/write sequence on the single-port balance store. It then returns a status and the resulting balance. It sits between the per-terminal ATM controllers and the balance memory, and it is the only block that drives the memory's ports.

## Interface
- `NUM_TERM`, 4: number of requesting terminals.
- `NUM_ACCTS`, 4: number of accounts in the store.
- `REG_WIDTH`, 12: balance and amount width.
- `ACCT_W`, `$clog2(NUM_ACCTS)`: account index width.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in `NUM_TERM`: per-terminal request level.
- `req_op` in `3*NUM_TERM`: packed op codes.
- `req_src` in `ACCT_W*NUM_TERM`: packed source account indices.
- `req_dst` in `ACCT_W*NUM_TERM`: packed destination account indices.
- `req_amount` in `REG_WIDTH*NUM_TERM`: packed amounts.
- `grant` out `NUM_TERM`: one-hot; marks the terminal currently being served.
- `done` out `NUM_TERM`: one-cycle pulse to the served terminal.
- `resp_status` out 3: status code, valid while `done` is high.
- `resp_balance` out `REG_WIDTH`: source balance after the transaction, valid while `done` is high.
- `busy` out 1: high in every state except IDLE.
- `db_rd_en` out 1: memory read enable. Data is returned 1 cycle later on `db_rd_data`.
- `db_addr` out `ACCT_W`: memory address.
- `db_rd_data` in `REG_WIDTH`: memory read data.
- `db_wr_en` out 1: memory write enable.
- `db_wr_data` out `REG_WIDTH`: memory write data.

## Operation
- Op codes:
  - 000 DEPOSIT
  - 001 WITHDRAW
  - 010 BALANCE
  - 011 TRANSFER
  - any other value is invalid.
- Status codes:
  - 0 OK
  - 1 INSUFFICIENT
  - 2 OVERFLOW
  - 3 BAD_ACCOUNT
  - 4 BAD_AMOUNT
  - 5 BAD_OP
- **IDLE**
  - Round-robin over `req`, starting at `rr_ptr`. `rr_ptr` resets to 0.
  - Latch the winner's fields and set `grant`.
  - Pre-checks, applied in this order:
    - invalid op → BAD_OP
    - src ≥ `NUM_ACCTS`, or (TRANSFER and (dst ≥ `NUM_ACCTS` or dst == src)) → BAD_ACCOUNT
    - amount == 0 on any op except BALANCE → BAD_AMOUNT
  - A pre-check failure goes to RESP with `resp_balance` = 0. Otherwise go to RD_SRC.
- **RD_SRC**: `db_rd_en`=1, `db_addr`=src. TRANSFER goes to RD_DST; all other ops go to EXEC.
- **RD_DST**: capture the source balance from `db_rd_data`. `db_rd_en`=1, `db_addr`=dst. Go to EXEC.
- **EXEC**: capture the last read. Compute with a `REG_WIDTH+1`-bit adder/subtractor.
  - BALANCE → RESP, status OK.
  - DEPOSIT: if bal+amt carries out → OVERFLOW; else go to WR_SRC.
  - WITHDRAW: if amt > bal → INSUFFICIENT; else go to WR_SRC.
  - TRANSFER: if amt > src_bal → INSUFFICIENT; else if dst_bal+amt carries out → OVERFLOW; else go to WR_SRC.
  - On an error, `resp_balance` = the unmodified source balance.
- **WR_SRC**: `db_wr_en`=1, `db_addr`=src, `db_wr_data`=new source balance. TRANSFER goes to WR_DST; other ops go to RESP.
- **WR_DST**: `db_wr_en`=1, `db_addr`=dst, `db_wr_data`=dst_bal+amt. Go to RESP.
- **RESP**
  - Assert `done[winner]` for one cycle and drive `resp_status` / `resp_balance`.
  - Set `rr_ptr` = winner+1 (mod `NUM_TERM`). Go to IDLE.
  - `grant` is cleared on the RESP→IDLE edge.
- Request handshake:
  - A terminal holds `req` and its fields stable until its `done` pulse.
  - It deasserts `req` in the `done` cycle.
  - If `req` is still high in the following IDLE, it is taken as a new transaction.
- Fields are latched in IDLE. Changes to a terminal's fields after grant are ignored.
- `db_wr_en` is asserted only in WR_SRC and WR_DST. `db_rd_en` is asserted only in RD_SRC and RD_DST.

## Timing
- Reset values:
  - State = IDLE, `rr_ptr` = 0.
  - `grant`, `done`, `busy`, `db_rd_en`, `db_wr_en` = 0.
  - `db_addr`, `db_wr_data`, `resp_status`, `resp_balance` = 0.
- Cycle counts below run from the IDLE cycle in which the request is sampled (cycle 0) to the cycle in which `done` is high:
  - pre-check error: 1
  - BALANCE: 3
  - DEPOSIT / WITHDRAW: 4
  - TRANSFER: 6
  - EXEC-stage error: 3 for a non-transfer, 4 for a TRANSFER
- All outputs are registered or decoded from the state register. No combinational path exists from `req` to the `db_*` outputs.
- Simultaneous requests: exactly one is granted. Others wait, and a waiting terminal is served within `NUM_TERM` transactions.
- Reset mid-operation aborts immediately with no further writes. A TRANSFER reset between WR_SRC and WR_DST leaves the source debited; recovering from that is the system's responsibility.

## Configuration
- `ATM_AUDIT_EN` defined:
  - adds outputs `ok_count` and `fail_count`, each 16 bits;
  - each increments in RESP according to the status, and saturates at 0xFFFF;
  - both reset to 0.
- `ATM_AUDIT_EN` undefined: the ports and counters do not exist.

## Structure
- `atm_pkg` holds:
  - the op-code and status-code constants;
  - the state enum (IDLE, RD_SRC, RD_DST, EXEC, WR_SRC, WR_DST, RESP);
  - the `REG_WIDTH` default.
- Sub-module `atm_rr_arbiter` (parameter `NUM_TERM`):
  - inputs: `req`, `rr_ptr`;
  - output: one-hot `winner`;
  - purely combinational.

## Test plan
- Memory preloaded with acct0=100 and acct1=50. Term0 does BALANCE on src=0 → `done[0]` at cycle 3, status OK, balance 100, no write.
- Term1 does WITHDRAW of 30 from acct0 → write 70 to acct0, `done[1]` at cycle 4, status OK, balance 70. Then WITHDRAW of 200 → INSUFFICIENT, balance 70, no `db_wr_en`.
- Term2 does TRANSFER of 20 from acct1 to acct0 → writes acct1=30 then acct0=90, `done` at cycle 6. TRANSFER with src=dst=1 → BAD_ACCOUNT at cycle 1.
- acct0=0xFF0. DEPOSIT of 0x020 → OVERFLOW, no write. DEPOSIT of 0 → BAD_AMOUNT. Op 111 → BAD_OP.
- All four terminals raise `req` in the same cycle → grants in order 0,1,2,3. Then term0 and term3 re-request → term0 is served first (`rr_ptr` has wrapped to 0).
- `rst_n` pulsed low during a TRANSFER's WR_SRC → `db_wr_en` drops immediately, acct0 is not written, outputs return to reset values. With `ATM_AUDIT_EN` defined, both counters read 0.

Source files
------------

// File: rtl/atm_pkg.sv
// -----------------------------------------------------------------------------
// atm_pkg
// Shared definitions for the ATM transaction scheduler:
//   - op-code constants (DEPOSIT, WITHDRAW, BALANCE, TRANSFER)
//   - response status constants
//   - scheduler state enum
//   - default balance/amount width
//   - small helper functions for request pre-checks
// -----------------------------------------------------------------------------
package atm_pkg;

    localparam int REG_WIDTH_DEF = 12;

    // Op codes
    localparam logic [2:0] OP_DEPOSIT  = 3'b000;
    localparam logic [2:0] OP_WITHDRAW = 3'b001;
    localparam logic [2:0] OP_BALANCE  = 3'b010;
    localparam logic [2:0] OP_TRANSFER = 3'b011;

    // Response status codes
    localparam logic [2:0] STS_OK           = 3'd0;
    localparam logic [2:0] STS_INSUFFICIENT = 3'd1;
    localparam logic [2:0] STS_OVERFLOW     = 3'd2;
    localparam logic [2:0] STS_BAD_ACCOUNT  = 3'd3;
    localparam logic [2:0] STS_BAD_AMOUNT   = 3'd4;
    localparam logic [2:0] STS_BAD_OP       = 3'd5;

    typedef enum logic [2:0] {
        IDLE,
        RD_SRC,
        RD_DST,
        EXEC,
        WR_SRC,
        WR_DST,
        RESP
    } state_e;

    // Valid op codes occupy the contiguous range 000..011.
    function automatic logic op_is_valid(input logic [2:0] op);
        return op <= OP_TRANSFER;
    endfunction

    // Account index check done at 32 bits so it stays meaningful when
    // NUM_ACCTS is not a power of two.
    function automatic logic idx_in_range(input int unsigned idx, input int unsigned limit);
        return idx < limit;
    endfunction

endpackage

// File: rtl/atm_rr_arbiter.sv
// -----------------------------------------------------------------------------
// atm_rr_arbiter
// Purely combinational round-robin arbiter. The request vector is rotated so
// that terminal rr_ptr sits at bit 0, the lowest set bit is isolated, and the
// result is rotated back.
// Ports:
//   req     in  NUM_TERM : request levels
//   rr_ptr  in  PTR_W    : highest-priority terminal index
//   winner  out NUM_TERM : one-hot grant candidate (all zero if no request)
// -----------------------------------------------------------------------------
module atm_rr_arbiter #(
    parameter int NUM_TERM = 4,
    parameter int PTR_W    = (NUM_TERM > 1) ? $clog2(NUM_TERM) : 1
) (
    input  logic [NUM_TERM-1:0] req,
    input  logic [PTR_W-1:0]    rr_ptr,
    output logic [NUM_TERM-1:0] winner
);

    logic [NUM_TERM-1:0] rot_req;
    logic [NUM_TERM-1:0] rot_pick;

    always_comb begin
        // Shifting by NUM_TERM (rr_ptr == 0) yields zero, so the OR is a clean rotate.
        rot_req  = (req >> rr_ptr) | (req << (NUM_TERM - int'(rr_ptr)));
        // x & -x keeps only the lowest set bit.
        rot_pick = rot_req & (~rot_req + NUM_TERM'(1));
        winner   = (rot_pick << rr_ptr) | (rot_pick >> (NUM_TERM - int'(rr_ptr)));
    end

endmodule

// File: rtl/atm_txn_scheduler.sv
// -----------------------------------------------------------------------------
// atm_txn_scheduler
// Shares one single-port account-balance store among NUM_TERM ATM front-ends.
// One request is picked round-robin, pre-checked, then run through a
// read / check / write sequence on the store, and answered with a status and
// the resulting source balance.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   req               : per-terminal request level
//   req_op/src/dst/amount : packed per-terminal request fields
//   grant             : one-hot, terminal currently being served
//   done              : one-cycle pulse to the served terminal
//   resp_status       : status code, valid with done
//   resp_balance      : source balance after the transaction, valid with done
//   busy              : high whenever the scheduler is not IDLE
//   db_rd_en/db_addr/db_rd_data/db_wr_en/db_wr_data : balance store port
//                       (read data returns one cycle after db_rd_en)
//
// Optional build macro ATM_AUDIT_EN adds 16-bit saturating ok_count and
// fail_count outputs, bumped once per response.
// -----------------------------------------------------------------------------
module atm_txn_scheduler
    import atm_pkg::*;
#(
    parameter int NUM_TERM  = 4,
    parameter int NUM_ACCTS = 4,
    parameter int REG_WIDTH = REG_WIDTH_DEF,
    parameter int ACCT_W    = $clog2(NUM_ACCTS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_TERM-1:0]           req,
    input  logic [3*NUM_TERM-1:0]         req_op,
    input  logic [ACCT_W*NUM_TERM-1:0]    req_src,
    input  logic [ACCT_W*NUM_TERM-1:0]    req_dst,
    input  logic [REG_WIDTH*NUM_TERM-1:0] req_amount,
    output logic [NUM_TERM-1:0]           grant,
    output logic [NUM_TERM-1:0]           done,
    output logic [2:0]                    resp_status,
    output logic [REG_WIDTH-1:0]          resp_balance,
    output logic                          busy,
    output logic                          db_rd_en,
    output logic [ACCT_W-1:0]             db_addr,
    input  logic [REG_WIDTH-1:0]          db_rd_data,
    output logic                          db_wr_en,
    output logic [REG_WIDTH-1:0]          db_wr_data
`ifdef ATM_AUDIT_EN
    ,
    output logic [15:0]                   ok_count,
    output logic [15:0]                   fail_count
`endif
);

    localparam int PTR_W = (NUM_TERM > 1) ? $clog2(NUM_TERM) : 1;

    // -------------------------------------------------------------------------
    // State and latched transaction
    // -------------------------------------------------------------------------
    state_e                state_q,   state_d;
    logic [PTR_W-1:0]      rr_ptr_q,  rr_ptr_d;
    logic [NUM_TERM-1:0]   grant_q,   grant_d;
    logic [PTR_W-1:0]      win_idx_q, win_idx_d;
    logic [2:0]            op_q,      op_d;
    logic [ACCT_W-1:0]     src_q,     src_d;
    logic [ACCT_W-1:0]     dst_q,     dst_d;
    logic [REG_WIDTH-1:0]  amt_q,     amt_d;
    logic [REG_WIDTH-1:0]  src_bal_q, src_bal_d;
    logic [REG_WIDTH-1:0]  new_src_q, new_src_d;
    logic [REG_WIDTH-1:0]  new_dst_q, new_dst_d;
    logic [2:0]            status_q,  status_d;
    logic [REG_WIDTH-1:0]  bal_q,     bal_d;

    // -------------------------------------------------------------------------
    // Arbitration and field selection
    // -------------------------------------------------------------------------
    logic [NUM_TERM-1:0]  winner;
    logic [PTR_W-1:0]     sel_idx;
    logic [2:0]           sel_op;
    logic [ACCT_W-1:0]    sel_src;
    logic [ACCT_W-1:0]    sel_dst;
    logic [REG_WIDTH-1:0] sel_amt;
    logic                 pre_fail;
    logic [2:0]           pre_status;

    atm_rr_arbiter #(
        .NUM_TERM (NUM_TERM),
        .PTR_W    (PTR_W)
    ) u_arb (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .winner (winner)
    );

    always_comb begin
        // NOTE: every variable gets a default before any conditional assignment;
        // a path that leaves one unassigned would infer a latch.
        sel_idx = '0;
        sel_op  = '0;
        sel_src = '0;
        sel_dst = '0;
        sel_amt = '0;
        for (int i = 0; i < NUM_TERM; i++) begin
            if (winner[i]) begin
                sel_idx = PTR_W'(i);
                sel_op  = req_op[3*i +: 3];
                sel_src = req_src[ACCT_W*i +: ACCT_W];
                sel_dst = req_dst[ACCT_W*i +: ACCT_W];
                sel_amt = req_amount[REG_WIDTH*i +: REG_WIDTH];
            end
        end
    end

    // Pre-checks are evaluated in priority order: op, account, amount.
    always_comb begin
        pre_fail   = 1'b0;
        pre_status = STS_OK;
        if (!op_is_valid(sel_op)) begin
            pre_fail   = 1'b1;
            pre_status = STS_BAD_OP;
        end else if (!idx_in_range(32'(sel_src), NUM_ACCTS) ||
                     ((sel_op == OP_TRANSFER) &&
                      (!idx_in_range(32'(sel_dst), NUM_ACCTS) || (sel_dst == sel_src)))) begin
            pre_fail   = 1'b1;
            pre_status = STS_BAD_ACCOUNT;
        end else if ((sel_op != OP_BALANCE) && (sel_amt == '0)) begin
            pre_fail   = 1'b1;
            pre_status = STS_BAD_AMOUNT;
        end
    end

    // -------------------------------------------------------------------------
    // EXEC arithmetic. For a TRANSFER the source balance was captured in
    // RD_DST and db_rd_data now carries the destination balance; for every
    // other op db_rd_data is the source balance. The adder therefore always
    // takes db_rd_data, and the extra MSB is the carry / borrow flag.
    // -------------------------------------------------------------------------
    logic [REG_WIDTH-1:0] exec_src;
    logic [REG_WIDTH:0]   add_res;
    logic [REG_WIDTH:0]   sub_res;

    assign exec_src = (op_q == OP_TRANSFER) ? src_bal_q : db_rd_data;
    assign add_res  = {1'b0, db_rd_data} + {1'b0, amt_q};
    assign sub_res  = {1'b0, exec_src}   - {1'b0, amt_q};

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        win_idx_d = win_idx_q;
        op_d      = op_q;
        src_d     = src_q;
        dst_d     = dst_q;
        amt_d     = amt_q;
        src_bal_d = src_bal_q;
        new_src_d = new_src_q;
        new_dst_d = new_dst_q;
        status_d  = status_q;
        bal_d     = bal_q;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d   = winner;
                    win_idx_d = sel_idx;
                    op_d      = sel_op;
                    src_d     = sel_src;
                    dst_d     = sel_dst;
                    amt_d     = sel_amt;
                    if (pre_fail) begin
                        status_d = pre_status;
                        bal_d    = '0;
                        state_d  = RESP;
                    end else begin
                        state_d  = RD_SRC;
                    end
                end
            end

            RD_SRC: state_d = (op_q == OP_TRANSFER) ? RD_DST : EXEC;

            RD_DST: begin
                src_bal_d = db_rd_data;
                state_d   = EXEC;
            end

            EXEC: begin
                // Error exits report the untouched source balance.
                status_d = STS_OK;
                bal_d    = exec_src;
                case (op_q)
                    OP_BALANCE: state_d = RESP;
                    OP_DEPOSIT: begin
                        if (add_res[REG_WIDTH]) begin
                            status_d = STS_OVERFLOW;
                            state_d  = RESP;
                        end else begin
                            new_src_d = add_res[REG_WIDTH-1:0];
                            bal_d     = add_res[REG_WIDTH-1:0];
                            state_d   = WR_SRC;
                        end
                    end
                    OP_WITHDRAW: begin
                        if (sub_res[REG_WIDTH]) begin
                            status_d = STS_INSUFFICIENT;
                            state_d  = RESP;
                        end else begin
                            new_src_d = sub_res[REG_WIDTH-1:0];
                            bal_d     = sub_res[REG_WIDTH-1:0];
                            state_d   = WR_SRC;
                        end
                    end
                    OP_TRANSFER: begin
                        if (sub_res[REG_WIDTH]) begin
                            status_d = STS_INSUFFICIENT;
                            state_d  = RESP;
                        end else if (add_res[REG_WIDTH]) begin
                            status_d = STS_OVERFLOW;
                            state_d  = RESP;
                        end else begin
                            new_src_d = sub_res[REG_WIDTH-1:0];
                            new_dst_d = add_res[REG_WIDTH-1:0];
                            bal_d     = sub_res[REG_WIDTH-1:0];
                            state_d   = WR_SRC;
                        end
                    end
                    default: begin
                        // Unreachable: invalid ops are rejected in IDLE.
                        status_d = STS_BAD_OP;
                        state_d  = RESP;
                    end
                endcase
            end

            WR_SRC: state_d = (op_q == OP_TRANSFER) ? WR_DST : RESP;

            WR_DST: state_d = RESP;

            RESP: begin
                rr_ptr_d = (win_idx_q == PTR_W'(NUM_TERM - 1)) ? '0 : win_idx_q + PTR_W'(1);
                grant_d  = '0;
                state_d  = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state is updated only with non-blocking assignments so
    // every register samples the pre-edge value of its inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            win_idx_q <= '0;
            op_q      <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            amt_q     <= '0;
            src_bal_q <= '0;
            new_src_q <= '0;
            new_dst_q <= '0;
            status_q  <= '0;
            bal_q     <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            win_idx_q <= win_idx_d;
            op_q      <= op_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            amt_q     <= amt_d;
            src_bal_q <= src_bal_d;
            new_src_q <= new_src_d;
            new_dst_q <= new_dst_d;
            status_q  <= status_d;
            bal_q     <= bal_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: registers or pure decodes of the state register, so nothing on
    // the store port depends combinationally on req.
    // -------------------------------------------------------------------------
    always_comb begin
        grant        = grant_q;
        done         = (state_q == RESP) ? grant_q : '0;
        resp_status  = status_q;
        resp_balance = bal_q;
        busy         = (state_q != IDLE);
        db_rd_en     = (state_q == RD_SRC) || (state_q == RD_DST);
        db_wr_en     = (state_q == WR_SRC) || (state_q == WR_DST);
        db_addr      = '0;
        db_wr_data   = '0;
        case (state_q)
            RD_SRC: db_addr = src_q;
            RD_DST: db_addr = dst_q;
            WR_SRC: begin
                db_addr    = src_q;
                db_wr_data = new_src_q;
            end
            WR_DST: begin
                db_addr    = dst_q;
                db_wr_data = new_dst_q;
            end
            default: ;
        endcase
    end

`ifdef ATM_AUDIT_EN
    // -------------------------------------------------------------------------
    // Audit counters: one bump per response, saturating at all-ones.
    // -------------------------------------------------------------------------
    logic [15:0] ok_cnt_q,   ok_cnt_d;
    logic [15:0] fail_cnt_q, fail_cnt_d;

    always_comb begin
        ok_cnt_d   = ok_cnt_q;
        fail_cnt_d = fail_cnt_q;
        if (state_q == RESP) begin
            if (status_q == STS_OK) begin
                if (ok_cnt_q != 16'hFFFF) ok_cnt_d = ok_cnt_q + 16'd1;
            end else begin
                if (fail_cnt_q != 16'hFFFF) fail_cnt_d = fail_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ok_cnt_q   <= '0;
            fail_cnt_q <= '0;
        end else begin
            ok_cnt_q   <= ok_cnt_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    assign ok_count   = ok_cnt_q;
    assign fail_count = fail_cnt_q;
`endif

endmodule

// File: tb/tb_atm_txn_scheduler.sv
// -----------------------------------------------------------------------------
// tb_atm_txn_scheduler
// Directed bench for atm_txn_scheduler with a one-cycle-latency balance store
// model. Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_atm_txn_scheduler;
    import atm_pkg::*;

    localparam int NT = 4;
    localparam int NA = 4;
    localparam int RW = 12;
    localparam int AW = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NT-1:0]    req;
    logic [3*NT-1:0]  req_op;
    logic [AW*NT-1:0] req_src;
    logic [AW*NT-1:0] req_dst;
    logic [RW*NT-1:0] req_amount;
    logic [NT-1:0]    grant;
    logic [NT-1:0]    done;
    logic [2:0]       resp_status;
    logic [RW-1:0]    resp_balance;
    logic             busy;
    logic             db_rd_en;
    logic [AW-1:0]    db_addr;
    logic [RW-1:0]    db_rd_data;
    logic             db_wr_en;
    logic [RW-1:0]    db_wr_data;
`ifdef ATM_AUDIT_EN
    logic [15:0]      ok_count;
    logic [15:0]      fail_count;
`endif

    // Per-terminal request fields, packed onto the DUT buses.
    logic [2:0]    op_a  [NT];
    logic [AW-1:0] src_a [NT];
    logic [AW-1:0] dst_a [NT];
    logic [RW-1:0] amt_a [NT];

    always_comb begin
        for (int i = 0; i < NT; i++) begin
            req_op[3*i +: 3]       = op_a[i];
            req_src[AW*i +: AW]    = src_a[i];
            req_dst[AW*i +: AW]    = dst_a[i];
            req_amount[RW*i +: RW] = amt_a[i];
        end
    end

    atm_txn_scheduler #(
        .NUM_TERM  (NT),
        .NUM_ACCTS (NA),
        .REG_WIDTH (RW),
        .ACCT_W    (AW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_op       (req_op),
        .req_src      (req_src),
        .req_dst      (req_dst),
        .req_amount   (req_amount),
        .grant        (grant),
        .done         (done),
        .resp_status  (resp_status),
        .resp_balance (resp_balance),
        .busy         (busy),
        .db_rd_en     (db_rd_en),
        .db_addr      (db_addr),
        .db_rd_data   (db_rd_data),
        .db_wr_en     (db_wr_en),
        .db_wr_data   (db_wr_data)
`ifdef ATM_AUDIT_EN
        ,
        .ok_count     (ok_count),
        .fail_count   (fail_count)
`endif
    );

    // Balance store model with a bench-side preload port.
    logic [RW-1:0] mem [NA];
    logic          pre_we   = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [RW-1:0] pre_data = '0;
    int            wr_cnt   = 0;
    logic [AW-1:0] last_wr_addr = '0;
    logic [AW-1:0] prev_wr_addr = '0;

    initial db_rd_data = '0;

    always @(posedge clk) begin
        if (db_rd_en) db_rd_data <= mem[db_addr];
        if (db_wr_en) begin
            mem[db_addr] <= db_wr_data;
            prev_wr_addr <= last_wr_addr;
            last_wr_addr <= db_addr;
            wr_cnt       <= wr_cnt + 1;
        end else if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic preload(input logic [AW-1:0] a, input logic [RW-1:0] d);
        @(negedge clk);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output int cyc, output bit got);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < max_cyc) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (done != '0) got = 1'b1;
        end
    endtask

    // One request from terminal t, checked for latency, done target, status,
    // balance and number of store writes.
    task automatic run_txn(input string name, input logic [1:0] t, input logic [2:0] op,
                           input logic [AW-1:0] src, input logic [AW-1:0] dst,
                           input logic [RW-1:0] amt, input int exp_lat,
                           input logic [2:0] exp_sts, input logic [RW-1:0] exp_bal,
                           input int exp_wr);
        int cyc;
        bit got;
        int wr0;
        @(negedge clk);
        op_a[t]  = op;
        src_a[t] = src;
        dst_a[t] = dst;
        amt_a[t] = amt;
        req[t]   = 1'b1;
        wr0      = wr_cnt;
        wait_done(20, cyc, got);
        req[t]   = 1'b0;
        n_cmp++;
        if (!got || cyc != exp_lat) begin
            n_bad++;
            $display("FAIL %s latency: got %0d (done seen=%0d) expected %0d", name, cyc, got, exp_lat);
        end
        n_cmp++;
        if (done !== (4'b0001 << t)) begin
            n_bad++;
            $display("FAIL %s done: got %b expected %b", name, done, 4'b0001 << t);
        end
        n_cmp++;
        if (resp_status !== exp_sts) begin
            n_bad++;
            $display("FAIL %s status: got %0d expected %0d", name, resp_status, exp_sts);
        end
        n_cmp++;
        if (resp_balance !== exp_bal) begin
            n_bad++;
            $display("FAIL %s balance: got %0d expected %0d", name, resp_balance, exp_bal);
        end
        n_cmp++;
        if (wr_cnt - wr0 != exp_wr) begin
            n_bad++;
            $display("FAIL %s writes: got %0d expected %0d", name, wr_cnt - wr0, exp_wr);
        end
    endtask

    task automatic check_mem(input string name, input logic [AW-1:0] a, input logic [RW-1:0] exp);
        n_cmp++;
        if (mem[a] !== exp) begin
            n_bad++;
            $display("FAIL %s mem[%0d]: got %0d expected %0d", name, a, mem[a], exp);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        n_cmp++;
        if (grant !== '0 || done !== '0 || busy !== 1'b0 || db_rd_en !== 1'b0 ||
            db_wr_en !== 1'b0 || db_addr !== '0 || db_wr_data !== '0 ||
            resp_status !== '0 || resp_balance !== '0) begin
            n_bad++;
            $display("FAIL %s outputs: grant=%b done=%b busy=%b rd=%b wr=%b addr=%0d wdata=%0d sts=%0d bal=%0d expected all zero",
                     name, grant, done, busy, db_rd_en, db_wr_en, db_addr, db_wr_data, resp_status, resp_balance);
        end
`ifdef ATM_AUDIT_EN
        n_cmp++;
        if (ok_count !== 16'd0 || fail_count !== 16'd0) begin
            n_bad++;
            $display("FAIL %s audit: ok=%0d fail=%0d expected 0/0", name, ok_count, fail_count);
        end
`endif
    endtask

    task automatic test_reset;
        req = '0;
        for (int i = 0; i < NT; i++) begin
            op_a[i]  = '0;
            src_a[i] = '0;
            dst_a[i] = '0;
            amt_a[i] = '0;
        end
        rst_n = 1'b0;
        #2;
        check_idle_outputs("reset");
        preload(2'd0, 12'd100);
        preload(2'd1, 12'd50);
        preload(2'd2, 12'd0);
        preload(2'd3, 12'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("post_reset");
    endtask

    task automatic test_balance;
        run_txn("balance", 2'd0, OP_BALANCE, 2'd0, 2'd0, 12'd0, 3, STS_OK, 12'd100, 0);
    endtask

    task automatic test_withdraw;
        run_txn("withdraw_ok", 2'd1, OP_WITHDRAW, 2'd0, 2'd0, 12'd30, 4, STS_OK, 12'd70, 1);
        check_mem("withdraw_ok", 2'd0, 12'd70);
        run_txn("withdraw_insuff", 2'd1, OP_WITHDRAW, 2'd0, 2'd0, 12'd200, 3, STS_INSUFFICIENT, 12'd70, 0);
    endtask

    task automatic test_transfer;
        run_txn("transfer_ok", 2'd2, OP_TRANSFER, 2'd1, 2'd0, 12'd20, 6, STS_OK, 12'd30, 2);
        check_mem("transfer_src", 2'd1, 12'd30);
        check_mem("transfer_dst", 2'd0, 12'd90);
        n_cmp++;
        if (prev_wr_addr !== 2'd1 || last_wr_addr !== 2'd0) begin
            n_bad++;
            $display("FAIL transfer_order: got %0d then %0d expected 1 then 0", prev_wr_addr, last_wr_addr);
        end
        run_txn("transfer_same", 2'd2, OP_TRANSFER, 2'd1, 2'd1, 12'd20, 1, STS_BAD_ACCOUNT, 12'd0, 0);
    endtask

    task automatic test_errors_and_limits;
        preload(2'd0, 12'hFF0);
        run_txn("deposit_ovf", 2'd3, OP_DEPOSIT, 2'd0, 2'd0, 12'h020, 3, STS_OVERFLOW, 12'hFF0, 0);
        run_txn("deposit_zero", 2'd3, OP_DEPOSIT, 2'd0, 2'd0, 12'h000, 1, STS_BAD_AMOUNT, 12'd0, 0);
        run_txn("bad_op", 2'd3, 3'b111, 2'd0, 2'd0, 12'd5, 1, STS_BAD_OP, 12'd0, 0);
        run_txn("deposit_full", 2'd3, OP_DEPOSIT, 2'd0, 2'd0, 12'h00F, 4, STS_OK, 12'hFFF, 1);
        check_mem("deposit_full", 2'd0, 12'hFFF);
        run_txn("withdraw_all", 2'd3, OP_WITHDRAW, 2'd0, 2'd0, 12'hFFF, 4, STS_OK, 12'd0, 1);
        check_mem("withdraw_all", 2'd0, 12'd0);
    endtask

    // Last served terminal was 3, so the pointer sits at 0.
    task automatic test_round_robin;
        int cyc;
        bit got;
        logic [NT-1:0] exp_order [6];
        exp_order[0] = 4'b0001;
        exp_order[1] = 4'b0010;
        exp_order[2] = 4'b0100;
        exp_order[3] = 4'b1000;
        exp_order[4] = 4'b0001;
        exp_order[5] = 4'b1000;
        @(negedge clk);
        for (int i = 0; i < NT; i++) begin
            op_a[i]  = OP_BALANCE;
            src_a[i] = 2'd1;
            dst_a[i] = 2'd0;
            amt_a[i] = 12'd0;
        end
        req = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            wait_done(10, cyc, got);
            n_cmp++;
            if (!got || done !== exp_order[k]) begin
                n_bad++;
                $display("FAIL rr_grant_%0d done: got %b expected %b", k, done, exp_order[k]);
            end
            n_cmp++;
            if (grant !== exp_order[k] || resp_balance !== 12'd30) begin
                n_bad++;
                $display("FAIL rr_grant_%0d grant/balance: got %b/%0d expected %b/30", k, grant, resp_balance, exp_order[k]);
            end
            req = req & ~done;
            if (k == 3) req = 4'b1001;
        end
        @(negedge clk);
        n_cmp++;
        if (done !== '0 || grant !== '0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rr_after done/grant/busy: got %b/%b/%b expected 0/0/0", done, grant, busy);
        end
    endtask

    task automatic test_reset_mid_transfer;
        int wr0;
        preload(2'd0, 12'd100);
        preload(2'd1, 12'd50);
        @(negedge clk);
        op_a[0]  = OP_TRANSFER;
        src_a[0] = 2'd1;
        dst_a[0] = 2'd0;
        amt_a[0] = 12'd10;
        req      = 4'b0001;
        wr0      = wr_cnt;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        n_cmp++;
        if (db_wr_en !== 1'b1 || db_addr !== 2'd1 || db_wr_data !== 12'd40) begin
            n_bad++;
            $display("FAIL rst_mid wr_src: got en=%b addr=%0d data=%0d expected 1/1/40", db_wr_en, db_addr, db_wr_data);
        end
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rst_mid");
        req = '0;
        @(posedge clk);
        @(negedge clk);
        check_mem("rst_mid_src", 2'd1, 12'd50);
        check_mem("rst_mid_dst", 2'd0, 12'd100);
        n_cmp++;
        if (wr_cnt != wr0) begin
            n_bad++;
            $display("FAIL rst_mid writes: got %0d expected 0", wr_cnt - wr0);
        end
        rst_n = 1'b1;
        run_txn("after_reset", 2'd0, OP_BALANCE, 2'd1, 2'd0, 12'd0, 3, STS_OK, 12'd50, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_balance();
        test_withdraw();
        test_transfer();
        test_errors_and_limits();
        test_round_robin();
        test_reset_mid_transfer();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
